async_fifo_wr_ctrl: RTL

//  Write-side pointer controller for a dual-clock FIFO. Accepts push requests, sequences a

---
 rtl/async_fifo_wr_ctrl_pkg.sv | 29 ++
 rtl/async_fifo_wr_ctrl_gray_counter.sv | 37 +++
 rtl/async_fifo_wr_ctrl_sync_1bit.sv | 22 ++
 rtl/async_fifo_wr_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/async_fifo_wr_ctrl_pkg.sv
// Shared definitions for the async FIFO write-side controller: flush FSM
// encodings, the synchroniser depth floor and the Gray-to-binary helper.
package async_fifo_wr_ctrl_pkg;

   // Flush handshake states, exported on the debug state output
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_CLR     = 2'd2,
      ST_WAIT_LO = 2'd3
   } flush_state_t;

   // Fewer than two flops does not give a metastability-settling window
   localparam int MIN_SYNC_STAGES = 2;

   // Widest pointer the helper handles; callers zero-extend narrower pointers
   localparam int PTR_MAX = 32;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
   function automatic logic [PTR_MAX-1:0] gray_to_bin(input logic [PTR_MAX-1:0] i_gry);
      logic [PTR_MAX-1:0] v_bin;
      v_bin[PTR_MAX-1] = i_gry[PTR_MAX-1];
      for (int i = PTR_MAX - 2; i >= 0; i--) begin
         v_bin[i] = v_bin[i+1] ^ i_gry[i];
      end
      return v_bin;
   endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_gray_counter.sv
// Binary/Gray pointer counter. Both encodings are registered so the Gray
// value can cross clock domains glitch-free. Clear has priority over enable.
module gray_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   input  logic         i_clr,
   output logic [W-1:0] o_bin,
   output logic [W-1:0] o_gry
);

   logic [W-1:0] r_bin;
   logic [W-1:0] r_gry;
   logic [W-1:0] w_bin_nxt;

   assign w_bin_nxt = r_bin + 1'b1;

   // Advance both encodings together; wrap is natural modulo 2**W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin <= '0;
         r_gry <= '0;
      end else if (i_clr) begin
         r_bin <= '0;
         r_gry <= '0;
      end else if (i_en) begin
         r_bin <= w_bin_nxt;
         r_gry <= w_bin_nxt ^ (w_bin_nxt >> 1);
      end
   end

   assign o_bin = r_bin;
   assign o_gry = r_gry;

endmodule

// File: rtl/async_fifo_wr_ctrl_sync_1bit.sv
// Single-bit synchroniser: a plain chain of STAGES flops with nothing in
// front of the first flop, reset to 0.
module sync_1bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   // Shift the asynchronous input through the flop chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO (write clock domain).
// Optional occupancy outputs are built when ASYNC_FIFO_WR_LEVEL_EN is defined;
// otherwise o_wr_level and o_wr_almost_full are tied to 0.
//
// Push handshake: i_wr_push acts as valid and !o_wr_full as ready. A push is
// accepted in any cycle where both hold (and no flush is running); o_wr_mem_en
// marks that cycle combinationally and the pointer moves on the next edge.
// A push while full is dropped without side effects.
module async_fifo_wr_ctrl
   import async_fifo_wr_ctrl_pkg::*;
#(
   parameter int W_ADDR      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AF_MARGIN   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr_push,
   output logic              o_wr_full,
   output logic              o_wr_mem_en,
   output logic [W_ADDR-1:0] o_wr_addr,
   output logic [W_ADDR:0]   o_wptr_gry,
   input  logic [W_ADDR:0]   i_rptr_gry_async,
   input  logic              i_flush_req,
   output logic              o_flush_busy,
   output logic              o_flush_remote_req,
   input  logic              i_flush_remote_ack,
   output logic [W_ADDR:0]   o_wr_level,
   output logic              o_wr_almost_full,
   output logic [1:0]        o_flush_state
);

   localparam int SYNC_N = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

   flush_state_t     r_state;
   flush_state_t     w_next_state;
   logic             r_flush_remote_req;
   logic             w_accept;
   logic             w_clr;
   logic             w_full_raw;
   logic             w_ack_sync;
   logic [W_ADDR:0]  w_wptr_bin;
   logic [W_ADDR:0]  w_wptr_gry;
   logic [W_ADDR:0]  w_rsync;

   assign w_accept = i_wr_push & ~o_wr_full & (r_state == ST_IDLE);
   assign w_clr    = (r_state == ST_CLR);

   gray_counter #(.W(W_ADDR + 1)) u_wptr (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_accept),
      .i_clr (w_clr),
      .o_bin (w_wptr_bin),
      .o_gry (w_wptr_gry)
   );

   // Read pointer crosses bit by bit; Gray coding keeps the sampled word coherent
   for (genvar g = 0; g <= W_ADDR; g++) begin : g_rsync
      sync_1bit #(.STAGES(SYNC_N)) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .i_d   (i_rptr_gry_async[g]),
         .o_q   (w_rsync[g])
      );
   end

   sync_1bit #(.STAGES(SYNC_N)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (i_flush_remote_ack),
      .o_q   (w_ack_sync)
   );

   // Full when the write pointer is exactly one lap ahead of the synced read pointer
   assign w_full_raw = (w_wptr_gry == {~w_rsync[W_ADDR:W_ADDR-1], w_rsync[W_ADDR-2:0]});

   // Flush FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // Flush FSM next-state: four-phase req/ack with the read domain
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:    if (i_flush_req) w_next_state = ST_REQ;
         ST_REQ:     if (w_ack_sync)  w_next_state = ST_CLR;
         ST_CLR:                      w_next_state = ST_WAIT_LO;
         ST_WAIT_LO: if (!w_ack_sync) w_next_state = ST_IDLE;
         default:                     w_next_state = ST_IDLE;
      endcase
   end

   // Flush FSM outputs: the remote request is a flop so the read side sees a clean level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_flush_remote_req <= 1'b0;
      else        r_flush_remote_req <= (w_next_state == ST_REQ);
   end

   assign o_flush_busy       = (r_state != ST_IDLE);
   assign o_flush_remote_req = r_flush_remote_req;
   assign o_flush_state      = r_state;
   assign o_wr_full          = w_full_raw | o_flush_busy;
   assign o_wr_mem_en        = w_accept;
   assign o_wr_addr          = w_wptr_bin[W_ADDR-1:0];
   assign o_wptr_gry         = w_wptr_gry;

`ifdef ASYNC_FIFO_WR_LEVEL_EN
   // Occupancy from the writer's view; lags real reads by the sync delay
   assign o_wr_level = (W_ADDR+1)'(32'(w_wptr_bin) - gray_to_bin(32'(w_rsync)));
   assign o_wr_almost_full = (o_wr_level >= (W_ADDR+1)'((2 ** W_ADDR) - AF_MARGIN));
`else
   logic w_unused_level_inputs;
   assign w_unused_level_inputs = w_wptr_bin[W_ADDR] ^ (AF_MARGIN != 0);
   assign o_wr_level       = '0;
   assign o_wr_almost_full = 1'b0;
`endif

endmodule
